fetch_align_buffer: RTL
=======================

FETCH_ALIGN_BUFFER -- requirements
Module: fetch_align_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue capacity in 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_req_o  output  1  one-cycle fetch request pulse.
REQ-006 SHALL have port mem_addr_o  output  32  word-aligned fetch address, valid while mem_req_o=1.
REQ-007 SHALL have port mem_rvalid_i  input  1  fetch response strobe.
REQ-008 SHALL have port mem_rdata_i  input  32  fetched word, valid with mem_rvalid_i.
REQ-009 SHALL have port redirect_i  input  1  flush and restart the fetch stream (branch/jump/trap/mret).
REQ-010 SHALL have port redirect_pc_i  input  32  new PC, halfword-aligned; bit0 is ignored.
REQ-011 SHALL have port instr_valid_o  output  1  instr_o/instr_pc_o hold a complete instruction.
REQ-012 SHALL have port instr_ready_i  input  1  decode accepts the instruction this cycle.
REQ-013 SHALL have port instr_o  output  32  instruction; compressed ones zero-extended in [15:0].
REQ-014 SHALL have port instr_pc_o  output  32  address of instr_o.
REQ-015 SHALL have port instr_compressed_o  output  1  instr_o[1:0] != 2'b11.

Function
REQ-016 SHALL hold at most one outstanding fetch; issue mem_req_o only when (words queued + outstanding) < DEPTH and redirect_i=0.
REQ-017 SHALL increment the fetch address by 4 per request issued.
REQ-018 SHALL write mem_rdata_i into the queue on mem_rvalid_i; the word is visible on instr_* the next cycle.
REQ-019 SHALL track a halfword read offset (0 or 2) into the head word.
REQ-020 SHALL assert instr_valid_o for a compressed instruction when its halfword is queued; for a 32-bit instruction only when both halfwords are queued, including when it spans the head and next word.
REQ-021 SHALL drive instr_valid_o, instr_o, instr_pc_o combinationally from queue state.
REQ-022 SHALL, on instr_valid_o & instr_ready_i, advance instr_pc_o by 2 (compressed) or 4 and pop every fully consumed word.
REQ-023 SHALL, on redirect_i, in the same edge: empty the queue; set fetch address to redirect_pc_i & ~3; set offset to redirect_pc_i[1]; set instr_pc_o base to redirect_pc_i & ~1.
REQ-024 SHALL discard a response returning for a request issued before a redirect.
REQ-025 SHALL give redirect_i priority over a simultaneous handshake and a simultaneous mem_rvalid_i.
REQ-026 SHALL hold instr_* stable while instr_valid_o=1 and instr_ready_i=0.
REQ-027 SHALL accept a push and a pop in the same cycle when full; no word is lost.
REQ-028 SHALL wrap fetch address 32'hFFFF_FFFC -> 32'h0000_0000.

Reset
REQ-029 SHALL, while rst=0: mem_req_o=0, instr_valid_o=0, queue empty, no outstanding fetch, fetch address=RESET_PC, offset=RESET_PC[1].
REQ-030 SHALL issue the first request (mem_addr_o=RESET_PC & ~3) in the first cycle after rst deasserts.
REQ-031 SHALL drop any in-flight response when reset is asserted mid-fetch.

Configuration
REQ-032 SHALL, with FAB_COMPRESSED_EN defined, implement the 16/32-bit alignment of REQ-019..REQ-023.
REQ-033 SHALL, without FAB_COMPRESSED_EN: treat every instruction as 32-bit, tie instr_compressed_o=0, advance by 4 only, and ignore redirect_pc_i[1:0].

Verification
REQ-034 SHALL cover: reset release, memory returns 32'h0000_0013 for addr 0 after 1 cycle -> instr_valid_o=1, instr_o=32'h0000_0013, instr_pc_o=0, instr_compressed_o=0.
REQ-035 SHALL cover: word0=32'h0001_4501 (c.li, then upper half 16'h0001) -> two compressed instructions, pc 0 and 2, instr_o 32'h0000_4501 then 32'h0000_0001.
REQ-036 SHALL cover: redirect_pc_i=32'h0000_0102, word@0x100=32'h0093_xxxx, word@0x104=32'hxxxx_0050 -> instr_o=32'h0050_0093, instr_pc_o=32'h102 after both words arrive.
REQ-037 SHALL cover: instr_ready_i=0 for 10 cycles with DEPTH=4 -> exactly 4 requests issued, then mem_req_o stays 0 and instr_* unchanged.
REQ-038 SHALL cover: redirect_i to 32'h200 while a fetch is outstanding, stale response 32'hDEAD_BEEF arrives -> stale data never appears on instr_o; next instr_pc_o=32'h200.
REQ-039 SHALL cover: build without FAB_COMPRESSED_EN, word 32'h0001_4501 -> single instruction, instr_o=32'h0001_4501, instr_compressed_o=0, next pc 4.

Source files
------------

// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer: instruction fetch queue with halfword alignment.
// It issues one word fetch at a time into a DEPTH-word queue. It then presents
// whole instructions to decode together with their PC.
// Build option: define FAB_COMPRESSED_EN to enable 16/32-bit instruction
// alignment. Without it, every instruction is a 32-bit word.
module fetch_align_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_compressed_o
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          outst_q, outst_d;   // a fetch is in flight
    logic          stale_q, stale_d;   // the in-flight fetch predates a redirect
    logic          off_q, off_d;       // 1: head instruction starts at upper halfword
    logic [31:0]   faddr_q, faddr_d;
    logic [31:0]   pc_q, pc_d;

    logic [31:0]   head_w;
    logic          push, fire, pop_w, off_adv, is_c, redir_off;
    logic [31:0]   pc_step, redir_pc;

    assign head_w = mem_q[rd_ptr_q];

`ifdef FAB_COMPRESSED_EN
    localparam logic [31:0] RESET_IPC = {RESET_PC[31:1], 1'b0};
    localparam logic        RESET_OFF = RESET_PC[1];

    logic [31:0] next_w;
    logic [15:0] lo_half;

    assign next_w   = mem_q[rd_ptr_q + AW'(1)];
    assign lo_half  = off_q ? head_w[31:16] : head_w[15:0];
    assign is_c     = (lo_half[1:0] != 2'b11);
    // A 32-bit instruction at the upper halfword also needs the following word.
    assign instr_valid_o = (cnt_q != '0) && (is_c || !off_q || (cnt_q >= (AW+1)'(2)));
    assign instr_o  = is_c  ? {16'h0000, lo_half} :
                      off_q ? {next_w[15:0], head_w[31:16]} : head_w;
    // The head word is used up once an instruction ends at its upper halfword.
    assign pop_w     = !is_c || off_q;
    assign off_adv   = is_c ? !off_q : off_q;
    assign pc_step   = is_c ? 32'd2 : 32'd4;
    assign redir_off = redirect_pc_i[1];
    assign redir_pc  = {redirect_pc_i[31:1], 1'b0};
`else
    localparam logic [31:0] RESET_IPC = {RESET_PC[31:2], 2'b00};
    localparam logic        RESET_OFF = 1'b0;

    logic unused_redir_bits;

    assign unused_redir_bits = ^redirect_pc_i[1:0];
    assign is_c          = 1'b0;
    assign instr_valid_o = (cnt_q != '0);
    assign instr_o       = head_w;
    assign pop_w         = 1'b1;
    assign off_adv       = 1'b0;
    assign pc_step       = 32'd4;
    assign redir_off     = 1'b0;
    assign redir_pc      = {redirect_pc_i[31:2], 2'b00};
`endif

    assign instr_compressed_o = is_c;
    assign instr_pc_o         = pc_q;
    assign mem_addr_o         = faddr_q;
    // Only one fetch may be in flight, and it must have a free queue slot waiting for it.
    assign mem_req_o = rst && !redirect_i && !outst_q && (cnt_q < DEPTH_C);
    assign fire      = instr_valid_o && instr_ready_i;
    // A response is kept only when it answers a request from the current stream.
    assign push      = mem_rvalid_i && outst_q && !stale_q && !redirect_i;

    // Next-state logic: a redirect overrides any handshake or response in the same cycle.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        outst_d  = outst_q;
        stale_d  = stale_q;
        off_d    = off_q;
        faddr_d  = faddr_q;
        pc_d     = pc_q;
        if (redirect_i) begin
            rd_ptr_d = wr_ptr_q;
            cnt_d    = '0;
            outst_d  = outst_q && !mem_rvalid_i;
            stale_d  = outst_q && !mem_rvalid_i;
            off_d    = redir_off;
            faddr_d  = {redirect_pc_i[31:2], 2'b00};
            pc_d     = redir_pc;
        end else begin
            if (mem_rvalid_i && outst_q) begin
                outst_d = 1'b0;
                stale_d = 1'b0;
            end
            if (mem_req_o) begin
                outst_d = 1'b1;
                faddr_d = faddr_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (fire) begin
                pc_d  = pc_q + pc_step;
                off_d = off_adv;
                if (pop_w) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
            end
            case ({push, fire && pop_w})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            outst_q  <= 1'b0;
            stale_q  <= 1'b0;
            off_q    <= RESET_OFF;
            faddr_q  <= {RESET_PC[31:2], 2'b00};
            pc_q     <= RESET_IPC;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            outst_q  <= outst_d;
            stale_q  <= stale_d;
            off_q    <= off_d;
            faddr_q  <= faddr_d;
            pc_q     <= pc_d;
        end
    end

    // Queue storage. It is data only, so it has no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

endmodule
